// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared FSM encoding and elaboration-time helpers for the
// PWM/pulse capture block (period and active-time measurement in 1 us units).
package pwm_capture_pkg;

  // Measurement FSM: IDLE waits for the arming edge, MEAS counts between edges.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } state_t;

  // Terminal value of the 1 us prescaler for a given clock frequency in Hz.
  function automatic int presc_max(input int unsigned clk_freq);
    return int'(clk_freq / 32'd1_000_000) - 32'sd1;
  endfunction

  // The timeout must be reachable below counter saturation (2^cnt_w - 1).
  function automatic bit timeout_ok(input int cnt_w, input longint timeout_us);
    longint lim;
    lim = (64'sd1 <<< cnt_w) - 64'sd1;
    return (timeout_us < lim);
  endfunction

endpackage

// File: rtl/pwm_capture_in_conditioner.sv
// pwm_in_conditioner: synchronises the asynchronous pulse pin, optionally
// glitch-filters it (macro PWM_CAPTURE_GLITCH_FILTER_EN), and produces the
// registered active flag plus a one-clock active-rise pulse.
// Pin-to-act_rise latency is 3 clocks, or 3+FILTER_LEN with the filter.
module pwm_in_conditioner #(
  parameter logic IN_VALID_LEVEL = 1'b1,
  parameter int   FILTER_LEN     = 4
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic pwm_in,
  output logic act,
  output logic act_rise
);

  logic sync1_r;
  logic sync2_r;
  logic lvl_s;
  logic act_r;
  logic act_d1_r;

  if (FILTER_LEN < 1) begin : g_filter_len_check
    $error("pwm_in_conditioner: FILTER_LEN must be at least 1");
  end

  // Two-flop synchroniser; resets to the inactive level so no edge is seen at release.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_r <= ~IN_VALID_LEVEL;
      sync2_r <= ~IN_VALID_LEVEL;
    end else begin
      sync1_r <= pwm_in;
      sync2_r <= sync1_r;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [FILT_W-1:0] filt_cnt_r;
  logic              filt_r;

  // Filtered level follows the synced level only after FILTER_LEN identical differing samples.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      filt_r     <= ~IN_VALID_LEVEL;
      filt_cnt_r <= '0;
    end else if (sync2_r == filt_r) begin
      filt_cnt_r <= '0;
    end else if (filt_cnt_r == FILT_W'(FILTER_LEN - 1)) begin
      filt_r     <= sync2_r;
      filt_cnt_r <= '0;
    end else begin
      filt_cnt_r <= filt_cnt_r + FILT_W'(1);
    end
  end

  assign lvl_s = filt_r;
`else
  assign lvl_s = sync2_r;
`endif

  // Active flag and its one-clock-delayed copy for rise detection.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      act_r    <= 1'b0;
      act_d1_r <= 1'b0;
    end else begin
      act_r    <= (lvl_s == IN_VALID_LEVEL);
      act_d1_r <= act_r;
    end
  end

  assign act      = act_r;
  assign act_rise = act_r & ~act_d1_r;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and active-level time of an external pulse
// input in 1 us units, publishes each result with a one-clock meas_valid
// strobe and raises sig_lost after TIMEOUT_US without an active edge.
// Optional glitch filter: define PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 32'd50_000_000,
  parameter int          CNT_W          = 20,
  parameter int unsigned TIMEOUT_US     = 32'd100_000,
  parameter logic        IN_VALID_LEVEL = 1'b1,
  parameter int          FILTER_LEN     = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_active,
  output logic             meas_valid,
  output logic             sig_lost
);

  localparam int PRESC_MAX = presc_max(CLK_FREQ);
  localparam int PRESC_W   = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;

  if (!timeout_ok(CNT_W, longint'(TIMEOUT_US))) begin : g_timeout_check
    $error("pwm_capture: TIMEOUT_US must be below 2^CNT_W - 1");
  end

  if ((CLK_FREQ % 32'd1_000_000) != 32'd0) begin : g_clk_freq_check
    $error("pwm_capture: CLK_FREQ must be a multiple of 1 MHz");
  end

  logic [PRESC_W-1:0] presc_r;
  logic               tick_1us_s;
  logic               act_s;
  logic               act_rise_s;

  state_t             state_r,       state_nxt_s;
  logic [CNT_W-1:0]   per_cnt_r,     per_cnt_nxt_s;
  logic [CNT_W-1:0]   act_cnt_r,     act_cnt_nxt_s;
  logic [CNT_W-1:0]   meas_period_r, meas_period_nxt_s;
  logic [CNT_W-1:0]   meas_active_r, meas_active_nxt_s;
  logic               meas_valid_r,  meas_valid_nxt_s;
  logic               sig_lost_r,    sig_lost_nxt_s;
  logic               timeout_s;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  pwm_in_conditioner #(
    .IN_VALID_LEVEL (IN_VALID_LEVEL),
    .FILTER_LEN     (FILTER_LEN)
  ) u_cond (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pwm_in    (pwm_in),
    .act       (act_s),
    .act_rise  (act_rise_s)
  );

  assign tick_1us_s = (presc_r == PRESC_W'(PRESC_MAX));

  // Free-running 1 us prescaler; edges never realign it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc_r <= '0;
    end else if (tick_1us_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PRESC_W'(1);
    end
  end

  assign timeout_s = (per_cnt_r >= CNT_W'(TIMEOUT_US));

  // Next-state, counter and result logic; an active rise outranks a timeout.
  always_comb begin
    state_nxt_s       = state_r;
    per_cnt_nxt_s     = per_cnt_r;
    act_cnt_nxt_s     = act_cnt_r;
    meas_period_nxt_s = meas_period_r;
    meas_active_nxt_s = meas_active_r;
    meas_valid_nxt_s  = 1'b0;
    sig_lost_nxt_s    = sig_lost_r;
    case (state_r)
      ST_IDLE: begin
        per_cnt_nxt_s = '0;
        act_cnt_nxt_s = '0;
        if (act_rise_s) begin
          state_nxt_s = ST_MEAS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MEAS: begin
        if (act_rise_s) begin
          meas_period_nxt_s = per_cnt_r;
          meas_active_nxt_s = act_cnt_r;
          meas_valid_nxt_s  = 1'b1;
          sig_lost_nxt_s    = 1'b0;
          per_cnt_nxt_s     = '0;
          act_cnt_nxt_s     = '0;
        end else if (timeout_s) begin
          sig_lost_nxt_s    = 1'b1;
          meas_period_nxt_s = '0;
          meas_active_nxt_s = '0;
          per_cnt_nxt_s     = '0;
          act_cnt_nxt_s     = '0;
          state_nxt_s       = ST_IDLE;
        end else if (tick_1us_s) begin
          per_cnt_nxt_s = sat_inc(per_cnt_r);
          if (act_s) begin
            act_cnt_nxt_s = sat_inc(act_cnt_r);
          end else begin
            act_cnt_nxt_s = act_cnt_r;
          end
        end else begin
          per_cnt_nxt_s = per_cnt_r;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        per_cnt_nxt_s = '0;
        act_cnt_nxt_s = '0;
      end
    endcase
  end

  // State, counter and output registers; reset discards any partial measurement.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r       <= ST_IDLE;
      per_cnt_r     <= '0;
      act_cnt_r     <= '0;
      meas_period_r <= '0;
      meas_active_r <= '0;
      meas_valid_r  <= 1'b0;
      sig_lost_r    <= 1'b1;
    end else begin
      state_r       <= state_nxt_s;
      per_cnt_r     <= per_cnt_nxt_s;
      act_cnt_r     <= act_cnt_nxt_s;
      meas_period_r <= meas_period_nxt_s;
      meas_active_r <= meas_active_nxt_s;
      meas_valid_r  <= meas_valid_nxt_s;
      sig_lost_r    <= sig_lost_nxt_s;
    end
  end

  assign meas_period = meas_period_r;
  assign meas_active = meas_active_r;
  assign meas_valid  = meas_valid_r;
  assign sig_lost    = sig_lost_r;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed bench for pwm_capture. Runs with a 4 MHz clock
// (4 clocks per us) and a 500 us timeout so the run stays short; waveforms
// are the planned ones scaled to a 100 us period.
module tb_pwm_capture;

  localparam int unsigned CF  = 32'd4_000_000;
  localparam int          CPU = 4;
  localparam int unsigned TO  = 32'd500;
  localparam int          W   = 20;

  logic         sys_clk = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic         pwm_hi = 1'b0;
  logic         pwm_lo = 1'b1;
  logic [W-1:0] per_hi, act_hi, per_lo, act_lo;
  logic         val_hi, val_lo, lost_hi, lost_lo;

  int tests = 0;
  int fails = 0;
  int v_cnt = 0;
  int v_dbl = 0;
  int lo_cnt = 0;
  int lo_dbl = 0;
  logic v_prev = 1'b0;
  logic lo_prev = 1'b0;
  int base;

  always #5 sys_clk = ~sys_clk;

  pwm_capture #(.CLK_FREQ(CF), .CNT_W(W), .TIMEOUT_US(TO), .IN_VALID_LEVEL(1'b1), .FILTER_LEN(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pwm_in(pwm_hi),
    .meas_period(per_hi), .meas_active(act_hi), .meas_valid(val_hi), .sig_lost(lost_hi));

  pwm_capture #(.CLK_FREQ(CF), .CNT_W(W), .TIMEOUT_US(TO), .IN_VALID_LEVEL(1'b0), .FILTER_LEN(4)) dut_lo (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pwm_in(pwm_lo),
    .meas_period(per_lo), .meas_active(act_lo), .meas_valid(val_lo), .sig_lost(lost_lo));

  // Strobe counters; a strobe lasting more than one clock is recorded separately.
  always @(posedge sys_clk) begin
    if (val_hi) begin
      v_cnt <= v_cnt + 1;
      if (v_prev) v_dbl <= v_dbl + 1;
    end
    if (val_lo) begin
      lo_cnt <= lo_cnt + 1;
      if (lo_prev) lo_dbl <= lo_dbl + 1;
    end
    v_prev  <= val_hi;
    lo_prev <= val_lo;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    tests++;
    assert ((obs >= lo) && (obs <= hi)) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_us(input int n);
    wait_clk(n * CPU);
  endtask

  initial begin
    // Reset state
    wait_clk(5);
    check_eq("rst_period", per_hi, 0);
    check_eq("rst_active", act_hi, 0);
    check_eq("rst_valid", val_hi, 0);
    check_eq("rst_lost", lost_hi, 1);
    check_eq("rst_lost_lo", lost_lo, 1);
    sys_rst_n = 1'b1;
    wait_us(10);

    // 30 us high / 70 us low, three periods: first rise only arms
    for (int i = 0; i < 3; i++) begin
      base = v_cnt;
      pwm_hi = 1'b1;
      wait_us(3);
      if (i == 0) begin
        check_eq("arm_no_strobe", v_cnt - base, 0);
        check_eq("arm_lost", lost_hi, 1);
      end else begin
        check_eq("pwm_strobe", v_cnt - base, 1);
        check_rng("pwm_period", int'(per_hi), 99, 101);
        check_rng("pwm_active", int'(act_hi), 29, 31);
        check_eq("pwm_lost", lost_hi, 0);
      end
      wait_us(27);
      pwm_hi = 1'b0;
      wait_us(70);
    end

    // Rise then hold high until timeout
    base = v_cnt;
    pwm_hi = 1'b1;
    wait_us(3);
    check_eq("hold_strobe", v_cnt - base, 1);
    base = v_cnt;
    wait_us(477);
    check_eq("pre_to_lost", lost_hi, 0);
    wait_us(40);
    check_eq("to_lost", lost_hi, 1);
    check_eq("to_period", per_hi, 0);
    check_eq("to_active", act_hi, 0);
    check_eq("to_no_strobe", v_cnt - base, 0);

    // Resume: first rise re-arms, second rise measures
    pwm_hi = 1'b0;
    wait_us(70);
    base = v_cnt;
    pwm_hi = 1'b1;
    wait_us(3);
    check_eq("rearm_no_strobe", v_cnt - base, 0);
    check_eq("rearm_lost", lost_hi, 1);
    wait_us(27);
    pwm_hi = 1'b0;
    wait_us(70);
    base = v_cnt;
    pwm_hi = 1'b1;
    wait_us(3);
    check_eq("resume_strobe", v_cnt - base, 1);
    check_rng("resume_period", int'(per_hi), 99, 101);
    check_eq("resume_lost", lost_hi, 0);

    // 3-clock glitch in the middle of the low phase
    wait_us(27);
    pwm_hi = 1'b0;
    wait_us(35);
    base = v_cnt;
    pwm_hi = 1'b1;
    wait_clk(3);
    pwm_hi = 1'b0;
    wait_clk(10);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    check_eq("glitch_ignored", v_cnt - base, 0);
`else
    check_eq("glitch_strobe", v_cnt - base, 1);
    check_eq("glitch_short", (int'(per_hi) < 100), 1);
`endif
    wait_clk(35 * CPU - 13);
    base = v_cnt;
    pwm_hi = 1'b1;
    wait_us(3);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    check_eq("post_glitch_strobe", v_cnt - base, 1);
    check_rng("post_glitch_period", int'(per_hi), 99, 101);
    check_rng("post_glitch_active", int'(act_hi), 29, 31);
`else
    check_eq("post_glitch_strobe", v_cnt - base, 1);
`endif

    // 1 us high every 100 us
    pwm_hi = 1'b0;
    wait_us(99);
    for (int i = 0; i < 3; i++) begin
      base = v_cnt;
      pwm_hi = 1'b1;
      wait_us(1);
      pwm_hi = 1'b0;
      wait_us(2);
      if (i > 0) begin
        check_eq("narrow_strobe", v_cnt - base, 1);
        check_rng("narrow_period", int'(per_hi), 99, 101);
        check_rng("narrow_active", int'(act_hi), 0, 2);
      end
      wait_us(97);
    end

    // Asynchronous reset mid-period
    wait_us(40);
    check_eq("pre_rst_lost", lost_hi, 0);
    check_rng("pre_rst_period", int'(per_hi), 99, 101);
    sys_rst_n = 1'b0;
    #1;
    check_eq("arst_period", per_hi, 0);
    check_eq("arst_active", act_hi, 0);
    check_eq("arst_valid", val_hi, 0);
    check_eq("arst_lost", lost_hi, 1);
    wait_clk(2);
    sys_rst_n = 1'b1;
    wait_us(5);
    base = v_cnt;
    pwm_hi = 1'b1;
    wait_us(3);
    check_eq("post_rst_no_strobe", v_cnt - base, 0);
    check_eq("post_rst_lost", lost_hi, 1);
    wait_us(27);
    pwm_hi = 1'b0;
    wait_us(70);
    base = v_cnt;
    pwm_hi = 1'b1;
    wait_us(3);
    check_eq("post_rst_strobe", v_cnt - base, 1);
    check_rng("post_rst_period", int'(per_hi), 99, 101);
    pwm_hi = 1'b0;

    // Active-low input: 20 us low / 80 us high
    for (int i = 0; i < 3; i++) begin
      base = lo_cnt;
      pwm_lo = 1'b0;
      wait_us(3);
      if (i == 0) begin
        check_eq("lo_arm_no_strobe", lo_cnt - base, 0);
      end else begin
        check_eq("lo_strobe", lo_cnt - base, 1);
        check_rng("lo_period", int'(per_lo), 99, 101);
        check_rng("lo_active", int'(act_lo), 19, 21);
        check_eq("lo_lost", lost_lo, 0);
      end
      wait_us(17);
      pwm_lo = 1'b1;
      wait_us(80);
    end

    // Every strobe lasted exactly one clock
    check_eq("strobe_width", v_dbl, 0);
    check_eq("lo_strobe_width", lo_dbl, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
